// File: rtl/intc_dispatch_controller_if.sv
// Config write port and CPU irq/ack/eoi handshake of the INTC dispatch core.
// The master side is the CPU/bus; the slave side is the controller.
interface intc_dispatch_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] intc_write_address;
  logic [ADDR_WIDTH-1:0] intc_write_data;
  logic                  write_enable;
  logic                  cpu_ack;
  logic                  cpu_eoi;
  logic                  cpu_irq;
  logic [ADDR_WIDTH-1:0] isr_address;
  logic [1:0]            active_id;
  logic                  in_service;
  logic [3:0]            pending;

  modport master (
    output intc_write_address, intc_write_data, write_enable, cpu_ack, cpu_eoi,
    input  cpu_irq, isr_address, active_id, in_service, pending
  );

  modport slave (
    input  intc_write_address, intc_write_data, write_enable, cpu_ack, cpu_eoi,
    output cpu_irq, isr_address, active_id, in_service, pending
  );
endinterface

// File: rtl/intc_dispatch_controller.sv
// INTC dispatch core: edge-detects 4 interrupt lines, masks and arbitrates
// (fixed or round-robin), and hands one interrupt at a time to the CPU via
// an irq/ack/eoi handshake together with the source's ISR vector.
module intc_dispatch_controller #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [3:0] RESET_MASK = 4'hF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [3:0]                        irq_in,
  intc_dispatch_controller_if.slave         bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            active_id_q, active_id_d;
  logic [ADDR_WIDTH-1:0] isr_addr_q, isr_addr_d;
  logic [3:0]            pending_q, pending_d;
  logic [3:0]            irq_prev_q;
  logic [3:0]            mask_q, mask_d;
  logic                  rr_mode_q, rr_mode_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] isr_table_q [4];
  logic [ADDR_WIDTH-1:0] isr_table_d [4];

  logic [3:0] rise;
  logic [3:0] elig;
  logic [3:0] clr;
  logic       win_valid;
  logic [1:0] winner;
  logic [1:0] arb_base;
  logic [1:0] arb_idx;

  // Address bits outside the decoded field and upper data bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{bus.intc_write_address[ADDR_WIDTH-1:5],
                         bus.intc_write_address[1:0]};

  // Edge detect and eligibility
  always_comb begin
    rise = irq_in & ~irq_prev_q;
    elig = pending_q & ~mask_q;
  end

  // Arbitration: first eligible source scanning upward from the base, modulo 4
  always_comb begin
    win_valid = 1'b0;
    winner    = '0;
    arb_idx   = '0;
    arb_base  = rr_mode_q ? rr_ptr_q : 2'd0;
    for (int unsigned k = 0; k < 4; k++) begin
      arb_idx = arb_base + 2'(k);
      if (!win_valid && elig[arb_idx]) begin
        win_valid = 1'b1;
        winner    = arb_idx;
      end
    end
  end

  // Dispatch FSM: IDLE -> REQ (irq raised) -> SERVICE (acked) -> IDLE (eoi)
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    isr_addr_d  = isr_addr_q;
    rr_ptr_d    = rr_ptr_q;
    clr         = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          active_id_d = winner;
          isr_addr_d  = isr_table_q[winner];
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.cpu_ack) begin
          clr[active_id_q] = 1'b1;
          state_d          = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (bus.cpu_eoi) begin
          rr_ptr_d = active_id_q + 2'd1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new edge on the bit being acknowledged wins over the clear.
    pending_d = (pending_q & ~clr) | rise;
  end

  // Config register decode
  always_comb begin
    mask_d      = mask_q;
    rr_mode_d   = rr_mode_q;
    isr_table_d = isr_table_q;
    if (bus.write_enable) begin
      if (!bus.intc_write_address[4]) begin
        isr_table_d[bus.intc_write_address[3:2]] = bus.intc_write_data;
      end else if (bus.intc_write_address[3:2] == 2'd0) begin
        mask_d = bus.intc_write_data[3:0];
      end else if (bus.intc_write_address[3:2] == 2'd1) begin
        rr_mode_d = bus.intc_write_data[0];
      end
    end
  end

  // State and register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      active_id_q <= '0;
      isr_addr_q  <= '0;
      pending_q   <= '0;
      irq_prev_q  <= '0;
      mask_q      <= RESET_MASK;
      rr_mode_q   <= 1'b0;
      rr_ptr_q    <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        isr_table_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      active_id_q <= active_id_d;
      isr_addr_q  <= isr_addr_d;
      pending_q   <= pending_d;
      irq_prev_q  <= irq_in;
      mask_q      <= mask_d;
      rr_mode_q   <= rr_mode_d;
      rr_ptr_q    <= rr_ptr_d;
      isr_table_q <= isr_table_d;
    end
  end

  assign bus.cpu_irq     = (state_q == ST_REQ);
  assign bus.in_service  = (state_q == ST_SERVICE);
  assign bus.isr_address = isr_addr_q;
  assign bus.active_id   = active_id_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_intc_dispatch_controller.sv
// Bench for intc_dispatch_controller: a cycle model of the interrupt
// controller is checked against the DUT on every falling edge, and directed
// scenarios add literal expectations at key points.
module tb_intc_dispatch_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] irq_in = '0;
  bit         chk_en = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  intc_dispatch_controller_if #(.ADDR_WIDTH(32)) bus ();

  intc_dispatch_controller #(
    .ADDR_WIDTH (32),
    .RESET_MASK (4'hF)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_in (irq_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase: 0 = waiting for an eligible source, 1 = irq raised, 2 = in service
  int        m_phase = 0;
  bit [3:0]  m_pend = '0, m_prev = '0, m_mask = 4'hF;
  bit        m_rr = 1'b0;
  int        m_ptr = 0;
  bit [31:0] m_tab [4];
  bit [31:0] m_isr = '0;
  int        m_id = 0;
  bit [3:0]  m_rise, m_clr, m_elig;
  int        m_win, m_cand;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_pend = '0; m_prev = '0; m_mask = 4'hF;
      m_rr = 1'b0; m_ptr = 0; m_isr = '0; m_id = 0;
      for (int i = 0; i < 4; i++) m_tab[i] = '0;
    end else begin
      m_rise = irq_in & ~m_prev;
      m_prev = irq_in;
      m_clr  = '0;
      m_elig = m_pend & ~m_mask;
      if (m_phase == 0) begin
        m_win = -1;
        for (int k = 0; k < 4; k++) begin
          m_cand = ((m_rr ? m_ptr : 0) + k) % 4;
          if (m_win < 0 && m_elig[m_cand]) m_win = m_cand;
        end
        if (m_win >= 0) begin
          m_id = m_win; m_isr = m_tab[m_win]; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (bus.cpu_ack) begin m_clr[m_id] = 1'b1; m_phase = 2; end
      end else begin
        if (bus.cpu_eoi) begin m_ptr = (m_id + 1) % 4; m_phase = 0; end
      end
      m_pend = (m_pend & ~m_clr) | m_rise;
      if (bus.write_enable) begin
        if (bus.intc_write_address[4] == 1'b0)
          m_tab[bus.intc_write_address[3:2]] = bus.intc_write_data;
        else if (bus.intc_write_address[3:2] == 2'd0)
          m_mask = bus.intc_write_data[3:0];
        else if (bus.intc_write_address[3:2] == 2'd1)
          m_rr = bus.intc_write_data[0];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_irq",     32'(bus.cpu_irq),    32'(m_phase == 1));
      check("in_service",  32'(bus.in_service), 32'(m_phase == 2));
      check("isr_address", bus.isr_address,     m_isr);
      check("active_id",   32'(bus.active_id),  32'(m_id));
      check("pending",     32'(bus.pending),    32'(m_pend));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
    bus.write_enable       = 1'b1;
    bus.intc_write_address = addr;
    bus.intc_write_data    = data;
    step();
    bus.write_enable       = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] lines);
    irq_in = lines;
    step();
    irq_in = '0;
  endtask

  task automatic wait_irq();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.cpu_irq === 1'b1) seen = 1'b1;
      else step();
    end
    check("irq_wait", 32'(bus.cpu_irq), 32'd1);
  endtask

  task automatic serve(input logic [1:0] id, input logic [31:0] vec);
    wait_irq();
    check("serve_id",  32'(bus.active_id), 32'(id));
    check("serve_isr", bus.isr_address, vec);
    bus.cpu_ack = 1'b1;
    step();
    bus.cpu_ack = 1'b0;
    check("serve_insvc", 32'(bus.in_service), 32'd1);
    bus.cpu_eoi = 1'b1;
    step();
    bus.cpu_eoi = 1'b0;
    check("serve_done", 32'(bus.in_service), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.write_enable = 1'b0; bus.intc_write_address = '0; bus.intc_write_data = '0;
    bus.cpu_ack = 1'b0; bus.cpu_eoi = 1'b0;
    do_reset();
    chk_en = 1'b1;

    // Reset state
    check("rst_irq",  32'(bus.cpu_irq),    32'd0);
    check("rst_pend", 32'(bus.pending),    32'd0);
    check("rst_isr",  bus.isr_address,     32'd0);
    check("rst_id",   32'(bus.active_id),  32'd0);

    // Basic dispatch of source 2
    cfg_write(32'h08, 32'h0000_0200);
    cfg_write(32'h10, 32'h0);
    pulse(4'b0100);
    check("lat_pend", 32'(bus.pending), 32'h4);
    check("lat_irq0", 32'(bus.cpu_irq), 32'd0);
    step();
    check("lat_irq1", 32'(bus.cpu_irq), 32'd1);
    check("lat_isr",  bus.isr_address,  32'h200);
    check("lat_id",   32'(bus.active_id), 32'd2);
    bus.cpu_ack = 1'b1; step(); bus.cpu_ack = 1'b0;
    check("ack_insvc", 32'(bus.in_service), 32'd1);
    check("ack_pend",  32'(bus.pending),    32'd0);
    bus.cpu_eoi = 1'b1; step(); bus.cpu_eoi = 1'b0;
    check("eoi_idle", 32'(bus.in_service), 32'd0);

    // Fixed priority: 1 before 3; ignored address write in between
    cfg_write(32'h04, 32'h0000_0100);
    cfg_write(32'h0C, 32'h0000_0300);
    cfg_write(32'h18, 32'hFFFF_FFFF);
    pulse(4'b1010);
    serve(2'd1, 32'h100);
    check("next_after_eoi", 32'(bus.cpu_irq), 32'd0);
    step();
    check("next_irq", 32'(bus.cpu_irq), 32'd1);
    serve(2'd3, 32'h300);

    // Round robin: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) cfg_write(32'(i * 4), 32'h1000 + 32'(i));
    cfg_write(32'h14, 32'h1);
    cfg_write(32'h10, 32'h0);
    pulse(4'b1111);
    serve(2'd0, 32'h1000);
    pulse(4'b0001);
    serve(2'd1, 32'h1001);
    serve(2'd2, 32'h1002);
    serve(2'd3, 32'h1003);
    serve(2'd0, 32'h1000);

    // Masked source stays pending, dispatched after unmask
    cfg_write(32'h10, 32'h4);
    pulse(4'b0100);
    step(); step();
    check("mask_pend", 32'(bus.pending), 32'h4);
    check("mask_irq",  32'(bus.cpu_irq), 32'd0);
    cfg_write(32'h10, 32'h0);
    step();
    check("unmask_irq", 32'(bus.cpu_irq), 32'd1);
    serve(2'd2, 32'h1002);

    // Table rewrite and mask during REQ do not disturb the request
    pulse(4'b0001);
    wait_irq();
    cfg_write(32'h00, 32'h0000_DEAD);
    cfg_write(32'h10, 32'h1);
    check("hold_irq", 32'(bus.cpu_irq), 32'd1);
    check("hold_isr", bus.isr_address,  32'h1000);
    bus.cpu_ack = 1'b1; irq_in = 4'b0001;
    step();
    bus.cpu_ack = 1'b0; irq_in = '0;
    check("setwins_pend",  32'(bus.pending),    32'h1);
    check("setwins_insvc", 32'(bus.in_service), 32'd1);
    bus.cpu_eoi = 1'b1; step(); bus.cpu_eoi = 1'b0;
    step(); step();
    check("masked_quiet", 32'(bus.cpu_irq), 32'd0);

    // Stray ack/eoi in IDLE
    bus.cpu_ack = 1'b1; bus.cpu_eoi = 1'b1;
    step();
    bus.cpu_ack = 1'b0; bus.cpu_eoi = 1'b0;
    check("stray_irq",  32'(bus.cpu_irq),    32'd0);
    check("stray_svc",  32'(bus.in_service), 32'd0);
    check("stray_pend", 32'(bus.pending),    32'h1);

    // New vector used at the next arbitration; reset during SERVICE
    cfg_write(32'h10, 32'h0);
    wait_irq();
    check("new_vec", bus.isr_address, 32'h0000_DEAD);
    bus.cpu_ack = 1'b1; irq_in = 4'b0010;
    step();
    bus.cpu_ack = 1'b0; irq_in = '0;
    check("pre_rst_svc", 32'(bus.in_service), 32'd1);
    rst_n = 1'b0;
    step();
    check("rst_svc_insvc", 32'(bus.in_service), 32'd0);
    check("rst_svc_irq",   32'(bus.cpu_irq),    32'd0);
    check("rst_svc_pend",  32'(bus.pending),    32'd0);
    check("rst_svc_isr",   bus.isr_address,     32'd0);
    check("rst_svc_id",    32'(bus.active_id),  32'd0);
    rst_n = 1'b1;
    step(); step(); step();
    check("post_rst_quiet", 32'(bus.cpu_irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/intc_dispatch_controller.md
Name: intc_dispatch_controller

Overview:
- Interrupt controller core for the 4-source INTC.
- Edge-detects and latches interrupt requests, applies per-source masks, and arbitrates among pending sources using fixed or round-robin priority.
- Sequences one interrupt at a time to the CPU with an irq/ack/eoi handshake, presenting that source's ISR vector.
- Holds the 4-entry ISR address table and control registers, written through the INTC config write port.

Parameters:
- ADDR_WIDTH, 32, width of config address, write data and ISR vectors
- RESET_MASK, 4'hF, mask register value at reset (1 = source masked)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- irq_in  in  4  interrupt request lines, synchronous to clk, rising-edge triggered
- intc_write_address  in  ADDR_WIDTH  config write address
- intc_write_data  in  ADDR_WIDTH  config write data
- write_enable  in  1  config write strobe, one write per cycle
- cpu_ack  in  1  CPU accepts the presented interrupt
- cpu_eoi  in  1  CPU end-of-interrupt
- cpu_irq  out  1  interrupt request to CPU
- isr_address  out  ADDR_WIDTH  ISR vector of the active source
- active_id  out  2  index of the active source
- in_service  out  1  high while the CPU services an interrupt
- pending  out  4  latched pending bits, before masking

Behaviour:
- Config decode, on a write_enable cycle:
  - addr[4]=0: isr_table[addr[3:2]] <= write_data.
  - addr[4]=1, addr[3:2]=0: mask <= write_data[3:0].
  - addr[4]=1, addr[3:2]=1: rr_mode <= write_data[0].
  - Other addresses are ignored.
- Reset (rst_n=0 at a clk edge):
  - isr_table all 0, mask=RESET_MASK, rr_mode=0, rr_ptr=0, irq_prev=0, pending=0.
  - State=IDLE, cpu_irq=0, in_service=0, isr_address=0, active_id=0.
  - A reset asserted mid-handshake aborts the handshake with no residue.
- Edge detect: rise = irq_in & ~irq_prev; pending <= (pending & ~clr) | rise.
  - clr is a one-hot of active_id on an accepted ack.
  - If set and clear hit the same bit in one cycle, the set wins.
- Eligibility: elig = pending & ~mask.
- Arbitration:
  - Fixed mode (rr_mode=0): lowest eligible index wins.
  - RR mode (rr_mode=1): first eligible index searching upward from rr_ptr, modulo 4.
- FSM, IDLE:
  - If elig != 0, latch active_id=winner and isr_address=isr_table[winner], then go to REQ.
  - cpu_irq becomes visible the cycle after the decision.
- FSM, REQ:
  - cpu_irq=1; active_id and isr_address hold stable.
  - On cpu_ack: pending[active_id] cleared, go to SERVICE.
  - The request is not retracted if the source is masked or the table is rewritten meanwhile.
- FSM, SERVICE:
  - cpu_irq=0, in_service=1.
  - On cpu_eoi: go to IDLE, in_service=0, rr_ptr <= active_id+1 (wraps 3->0).
- Ignored inputs: cpu_ack outside REQ; cpu_eoi outside SERVICE.
- Latency:
  - irq_in rises before edge k: pending set after edge k; cpu_irq=1 after edge k+1, provided the source is unmasked and the FSM is IDLE.
  - After eoi at edge m, the next cpu_irq is asserted after edge m+1 at earliest.
- Nesting and re-arming:
  - No nesting; new edges during REQ/SERVICE only set pending.
  - A level held high does not re-trigger; it must fall and rise again.
- Masked pending bits stay latched and are dispatched after unmask.
- Config writes during REQ/SERVICE take effect for the next arbitration only.

Test Plan:
- Reset, then write isr_table[2]=0x0000_0200, mask=0, pulse irq_in[2] -> cpu_irq=1 two cycles after the rise; isr_address=0x200, active_id=2; ack gives in_service=1 and pending=0; eoi returns to IDLE.
- Fixed mode, irq_in[3] and irq_in[1] rise together -> id1 served first, then id3 after eoi; vectors match table entries.
- rr_mode=1, all four pending repeatedly -> service order 0,1,2,3,0 across consecutive eoi's.
- Mask=4'b0100, pulse irq_in[2] -> pending[2]=1, cpu_irq stays 0; write mask=0 -> cpu_irq=1 with active_id=2.
- During REQ for id0, rewrite isr_table[0]=0xDEAD and set mask[0]=1 -> isr_address keeps the old value and cpu_irq stays until ack; new irq_in[0] edge on the ack cycle leaves pending[0]=1.
- Stray cpu_ack/cpu_eoi in IDLE -> no state change; rst_n=0 during SERVICE -> all outputs 0 and pending=0 on the next cycle.
